mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq_pkg.sv | 18 +
 rtl/mix_column.sv | 39 +++
 rtl/xtime_byte.sv | 11 +
 rtl/mix_columns_seq.sv | 105 ++++++++++
 tb/tb_mix_columns_seq.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_seq_pkg.sv
// Shared AES constants and FSM state encoding for the sequential MixColumns engine.
package mix_columns_seq_pkg;

    localparam int BYTE     = 8;
    localparam int DWORD    = 32;
    localparam int SENTENCE = 128;

    // Reduction polynomial x^8 + x^4 + x^3 + x + 1, without the x^8 term
    localparam logic [7:0] RED_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mix_column.sv
// Combinational single-column MixColumns datapath with the InvMixColumns pre-step.
// The four doublers are shared: in pre mode they form two x4 chains, otherwise one x2 per byte.
module mix_column
    import mix_columns_seq_pkg::*;
(
    input  logic [31:0] col,
    input  logic        pre,
    output logic [31:0] pre_col,
    output logic [31:0] fwd_col
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d_in0, d_in1, d_in2, d_in3;
    logic [7:0] d_out0, d_out1, d_out2, d_out3;

    assign {a0, a1, a2, a3} = col;

    assign d_in0 = pre ? (a0 ^ a2) : a0;
    assign d_in1 = pre ? (a1 ^ a3) : a1;
    assign d_in2 = pre ? d_out0    : a2;
    assign d_in3 = pre ? d_out1    : a3;

    xtime_byte u_dbl0 (.a(d_in0), .y(d_out0));
    xtime_byte u_dbl1 (.a(d_in1), .y(d_out1));
    xtime_byte u_dbl2 (.a(d_in2), .y(d_out2));
    xtime_byte u_dbl3 (.a(d_in3), .y(d_out3));

    // Pre mode: d_out2 = x4(a0^a2), d_out3 = x4(a1^a3)
    assign pre_col = {a0 ^ d_out2, a1 ^ d_out3, a2 ^ d_out2, a3 ^ d_out3};

    // x3(a) = x2(a) ^ a
    assign fwd_col = {
        d_out0 ^ (d_out1 ^ a1) ^ a2 ^ a3,
        a0 ^ d_out1 ^ (d_out2 ^ a2) ^ a3,
        a0 ^ a1 ^ d_out2 ^ (d_out3 ^ a3),
        (d_out0 ^ a0) ^ a1 ^ a2 ^ d_out3
    };

endmodule

// File: rtl/xtime_byte.sv
// GF(2^8) doubling of one byte: shift left, then reduce when the top bit falls out.
module xtime_byte
    import mix_columns_seq_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential (Inv)MixColumns over a 128-bit AES state, one column per MIX cycle,
// with an extra PRE cycle per column for the inverse transform.
module mix_columns_seq
    import mix_columns_seq_pkg::*;
#(
    parameter int BYTE     = mix_columns_seq_pkg::BYTE,
    parameter int DWORD    = mix_columns_seq_pkg::DWORD,
    parameter int SENTENCE = mix_columns_seq_pkg::SENTENCE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                inv,
    input  logic [SENTENCE-1:0] state_in,
    output logic                busy,
    output logic                done,
    output logic [SENTENCE-1:0] state_out
);

    state_t              state_reg;
    logic [1:0]          col_reg;
    logic                inv_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [SENTENCE-1:0] work_reg;
    logic [SENTENCE-1:0] out_reg;
    logic [SENTENCE-1:0] work_next;

    logic [DWORD-1:0] cols [4];
    logic [DWORD-1:0] col_data;
    logic [DWORD-1:0] pre_col;
    logic [DWORD-1:0] fwd_col;
    logic [DWORD-1:0] new_col;

    // Column 0 sits in the most significant word
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign cols[gi] = work_reg[SENTENCE-1-DWORD*gi -: DWORD];
            assign work_next[SENTENCE-1-DWORD*gi -: DWORD] =
                (col_reg == 2'(gi)) ? new_col : cols[gi];
        end
    endgenerate

    assign col_data = cols[col_reg];
    assign new_col  = (state_reg == PRE) ? pre_col : fwd_col;

    mix_column u_mix_column (
        .col     (col_data),
        .pre     (state_reg == PRE),
        .pre_col (pre_col),
        .fwd_col (fwd_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            col_reg   <= 2'd0;
            inv_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            work_reg  <= '0;
            out_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        work_reg  <= state_in;
                        inv_reg   <= inv;
                        col_reg   <= 2'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= inv ? PRE : MIX;
                    end
                end
                PRE: begin
                    work_reg  <= work_next;
                    state_reg <= MIX;
                end
                MIX: begin
                    work_reg <= work_next;
                    if (col_reg == 2'd3) begin
                        out_reg   <= work_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        col_reg   <= col_reg + 2'd1;
                        state_reg <= inv_reg ? PRE : MIX;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign state_out = out_reg;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a matrix-multiply GF(2^8) reference.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         inv;
    logic [127:0] state_in;
    logic         busy;
    logic         done;
    logic [127:0] state_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inv       (inv),
        .state_in  (state_in),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (time=%0t) required=finish", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: state * circulant matrix over GF(2^8)
    function automatic logic [7:0] ref_x2(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], 1'b0};
        if (b[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ t;
            t = ref_x2(t);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic i);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   y;
        logic [127:0] r;
        r = '0;
        if (i) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                y = 8'h00;
                for (int k = 0; k < 4; k++) y = y ^ gmul(coef[(k - row + 4) % 4], a[k]);
                r[127-32*c-8*row -: 8] = y;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one operation; scrambles state_in/inv right after capture
    task automatic run_op(input logic [127:0] s, input logic i, output logic [127:0] res,
                          output int lat, output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        state_in = s;
        inv      = i;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        state_in = rand_state();
        inv      = ~i;
        lat      = 0;
        busy_ok  = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = state_out;
        @(posedge clk); #1;
        pulse_ok = (done === 1'b0);
        $display("op inv=%0d in=%h out=%h lat=%0d", i, s, res, lat);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        inv      = 1'b0;
        state_in = rand_state();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (state_out !== 128'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", state_out); end
        // first edge with rst low must accept start
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL first_start_busy got=%b exp=1", busy); end
        $display("reset released, first start busy=%b", busy);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        logic [127:0] res;
        int lat;
        bit bo, po;
        logic [127:0] exp31, exp32;
        exp31 = {32'h8e4da1bc, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6};
        exp32 = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c};
        run_op({32'hdb135345, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0, res, lat, bo, po);
        checks++;
        if (res !== exp31) begin failures++; $display("FAIL vec_fwd got=%h exp=%h", res, exp31); end
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL vec_fwd_lat got=%0d exp=4", lat); end
        checks++;
        if (po !== 1'b1) begin failures++; $display("FAIL vec_fwd_pulse got=%b exp=1", po); end
        run_op({32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8}, 1'b1, res, lat, bo, po);
        checks++;
        if (res !== exp32) begin failures++; $display("FAIL vec_inv got=%h exp=%h", res, exp32); end
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL vec_inv_lat got=%0d exp=8", lat); end
        checks++;
        if (po !== 1'b1) begin failures++; $display("FAIL vec_inv_pulse got=%b exp=1", po); end
    endtask

    task automatic test_random();
        logic [127:0] s, res, exp;
        logic i;
        int lat;
        bit bo, po;
        for (int n = 0; n < 8; n++) begin
            s   = rand_state();
            i   = 1'($urandom_range(0, 1));
            exp = ref_mix(s, i);
            run_op(s, i, res, lat, bo, po);
            checks++;
            if (res !== exp) begin failures++; $display("FAIL rand_out got=%h exp=%h", res, exp); end
            checks++;
            if (lat !== (i ? 8 : 4)) begin failures++; $display("FAIL rand_lat got=%0d exp=%0d", lat, i ? 8 : 4); end
            checks++;
            if (bo !== 1'b1) begin failures++; $display("FAIL rand_busy got=%b exp=1", bo); end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] s, r1, r2;
        int lat1, lat2;
        bit bo1, bo2, po;
        s = {4{32'hf20a225c}};
        run_op(s, 1'b0, r1, lat1, bo1, po);
        run_op(r1, 1'b1, r2, lat2, bo2, po);
        checks++;
        if (r1 !== ref_mix(s, 1'b0)) begin failures++; $display("FAIL trip_fwd got=%h exp=%h", r1, ref_mix(s, 1'b0)); end
        checks++;
        if (r2 !== s) begin failures++; $display("FAIL trip_back got=%h exp=%h", r2, s); end
        checks++;
        if (lat1 !== 4 || lat2 !== 8) begin failures++; $display("FAIL trip_lat got=%0d/%0d exp=4/8", lat1, lat2); end
        checks++;
        if (bo1 !== 1'b1 || bo2 !== 1'b1) begin failures++; $display("FAIL trip_busy got=%b/%b exp=1/1", bo1, bo2); end
    endtask

    task automatic test_ignore_start();
        logic [127:0] s1;
        int dones;
        s1 = rand_state();
        @(negedge clk);
        state_in = s1;
        inv      = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            state_in = rand_state();
            inv      = 1'($urandom_range(0, 1));
            start    = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        $display("ignore_start in=%h out=%h dones=%0d", s1, state_out, dones);
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL ignore_dones got=%0d exp=1", dones); end
        checks++;
        if (state_out !== ref_mix(s1, 1'b0)) begin failures++; $display("FAIL ignore_out got=%h exp=%h", state_out, ref_mix(s1, 1'b0)); end
    endtask

    task automatic test_reset_abort();
        logic [127:0] res, exp;
        int lat, bad;
        bit bo, po;
        @(negedge clk);
        state_in = rand_state();
        inv      = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (state_out !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got=%h/%b/%b exp=0/0/0", state_out, done, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || state_out !== 128'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL abort_leak got=%0d exp=0", bad); end
        exp = {4{32'h01010101}};
        run_op(exp, 1'b0, res, lat, bo, po);
        checks++;
        if (res !== exp) begin failures++; $display("FAIL abort_next got=%h exp=%h", res, exp); end
    endtask

    task automatic test_corners();
        logic [127:0] s, res;
        int lat;
        bit bo, po;
        s = {32'h80000000, 96'h0};
        run_op(s, 1'b0, res, lat, bo, po);
        checks++;
        if (res !== ref_mix(s, 1'b0)) begin failures++; $display("FAIL corner_80 got=%h exp=%h", res, ref_mix(s, 1'b0)); end
        run_op(s, 1'b1, res, lat, bo, po);
        checks++;
        if (res !== ref_mix(s, 1'b1)) begin failures++; $display("FAIL corner_80_inv got=%h exp=%h", res, ref_mix(s, 1'b1)); end
        for (int i = 0; i < 2; i++) begin
            run_op(128'h0, 1'(i), res, lat, bo, po);
            checks++;
            if (res !== 128'h0) begin failures++; $display("FAIL corner_zero inv=%0d got=%h exp=0", i, res); end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            state_in = rand_state();
            inv      = 1'(i);
            start    = 1'b1;
            n = 0;
            while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
            t1 = cyc;
            @(posedge clk); #1;
            n = 0;
            while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
            t2 = cyc;
            start = 1'b0;
            $display("back_to_back inv=%0d period=%0d", i, t2 - t1);
            checks++;
            if (t2 - t1 !== (i ? 10 : 6)) begin
                failures++;
                $display("FAIL b2b_period inv=%0d got=%0d exp=%0d", i, t2 - t1, i ? 10 : 6);
            end
            n = 0;
            while (busy !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_round_trip();
        test_ignore_start();
        test_reset_abort();
        test_corners();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
